// File: rtl/mem_link_pkg.sv
// Shared state encoding and sizing helpers for the memory link controller.
package mem_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA,
    RESP
  } state_t;

  function automatic int beats(input int wide_w, input int link_w);
    return wide_w / link_w;
  endfunction

  function automatic int bcnt_width(input int na, input int nd);
    int m;
    m = (na > nd) ? na : nd;
    return $clog2(m + 1);
  endfunction

  function automatic int tcnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_link_ctlr_beat_timer.sv
// Per-beat timeout counter: counts ack-less cycles of the current beat and
// flags the cycle whose edge would take the count to TIMEOUT.
module link_beat_timer
  import mem_link_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = tcnt_width(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // An ack in the final cycle keeps i_en low, so the ack wins over expiry.
  assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_link_ctlr.sv
// CPU request/response to narrow external link bridge: serialises address
// and data into strobe/ack beats with a per-beat timeout.
//
// state | meaning
// IDLE  | ready for a CPU request
// ADDR  | sending address beats, LS slice first
// WDATA | sending write data beats, LS slice first
// RDATA | collecting read data beats into the read register
// RESP  | one-cycle response pulse
module mem_link_ctlr
  import mem_link_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LINK_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [LINK_W-1:0] o_link_out,
  output logic              o_link_oe,
  input  logic [LINK_W-1:0] i_link_in,
  output logic              o_link_stb,
  output logic              o_link_we,
  input  logic              i_link_ack
);

  localparam int NA     = beats(ADDR_W, LINK_W);
  localparam int ND     = beats(DATA_W, LINK_W);
  localparam int BCNT_W = bcnt_width(NA, ND);

  state_t r_state, w_state_nxt;

  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_we, w_we_nxt;
  logic              w_err_nxt;

  logic              r_rsp_valid, r_rsp_err, r_link_oe, r_link_stb, r_link_we;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [LINK_W-1:0] r_link_out, w_link_out_nxt;
  logic              w_nxt_beat;

  logic w_in_beat, w_last, w_expired;

  assign w_in_beat = (r_state == ADDR) || (r_state == WDATA) || (r_state == RDATA);
  assign w_last    = (r_state == ADDR) ? (r_bcnt == BCNT_W'(NA - 1))
                                       : (r_bcnt == BCNT_W'(ND - 1));

  link_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (!w_in_beat || i_link_ack),
    .i_en      (w_in_beat && !i_link_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_we_nxt    = r_we;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_state_nxt = ADDR;
          w_bcnt_nxt  = '0;
          w_addr_nxt  = i_req_addr;
          w_wdata_nxt = i_req_wdata;
          w_rdata_nxt = '0;
          w_we_nxt    = i_req_we;
        end
      end
      ADDR, WDATA, RDATA: begin
        if (i_link_ack) begin
          if (r_state == ADDR)  w_addr_nxt  = r_addr >> LINK_W;
          if (r_state == WDATA) w_wdata_nxt = r_wdata >> LINK_W;
          // Shift in from the top so the first beat lands in the LS slice.
          if (r_state == RDATA)
            w_rdata_nxt = (r_rdata >> LINK_W) | (DATA_W'(i_link_in) << (DATA_W - LINK_W));
          if (w_last) begin
            w_bcnt_nxt = '0;
            if (r_state == ADDR) w_state_nxt = r_we ? WDATA : RDATA;
            else                 w_state_nxt = RESP;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt = RESP;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output values for the cycle after the edge, so every output is a flop.
  always_comb begin
    w_nxt_beat      = (w_state_nxt == ADDR) || (w_state_nxt == WDATA) || (w_state_nxt == RDATA);
    w_link_out_nxt  = '0;
    w_rsp_rdata_nxt = '0;
    if (w_state_nxt == ADDR)       w_link_out_nxt = w_addr_nxt[LINK_W-1:0];
    else if (w_state_nxt == WDATA) w_link_out_nxt = w_wdata_nxt[LINK_W-1:0];
    if ((w_state_nxt == RESP) && !w_err_nxt && !r_we) w_rsp_rdata_nxt = w_rdata_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_we        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_link_out  <= '0;
      r_link_oe   <= 1'b0;
      r_link_stb  <= 1'b0;
      r_link_we   <= 1'b0;
    end else begin
      r_bcnt      <= w_bcnt_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_we        <= w_we_nxt;
      r_rsp_valid <= (w_state_nxt == RESP);
      r_rsp_err   <= (w_state_nxt == RESP) && w_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_link_out  <= w_link_out_nxt;
      r_link_oe   <= (w_state_nxt == ADDR) || (w_state_nxt == WDATA);
      r_link_stb  <= w_nxt_beat;
      r_link_we   <= w_nxt_beat && w_we_nxt;
    end
  end

  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_link_out  = r_link_out;
  assign o_link_oe   = r_link_oe;
  assign o_link_stb  = r_link_stb;
  assign o_link_we   = r_link_we;

endmodule

// File: tb/tb_mem_link_ctlr.sv
// Directed bench: 32/32/16 instance with TIMEOUT=4 driven from a vector
// table, plus an 8-bit link instance and a mid-transaction reset sequence.
module tb_mem_link_ctlr;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_link_ack = 1'b0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [15:0] a_link_in = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_link_oe, a_link_stb, a_link_we;
  logic [31:0] a_rsp_rdata;
  logic [15:0] a_link_out;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_link_ack = 1'b0;
  logic [15:0] b_req_addr = '0;
  logic [63:0] b_req_wdata = '0;
  logic [7:0]  b_link_in = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_link_oe, b_link_stb, b_link_we;
  logic [63:0] b_rsp_rdata;
  logic [7:0]  b_link_out;

  mem_link_ctlr #(.ADDR_W(32), .DATA_W(32), .LINK_W(16), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_we(a_req_we),
    .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata),
    .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rsp_rdata), .o_rsp_err(a_rsp_err),
    .o_link_out(a_link_out), .o_link_oe(a_link_oe), .i_link_in(a_link_in),
    .o_link_stb(a_link_stb), .o_link_we(a_link_we), .i_link_ack(a_link_ack)
  );

  mem_link_ctlr #(.ADDR_W(16), .DATA_W(64), .LINK_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_we(b_req_we),
    .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
    .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err),
    .o_link_out(b_link_out), .o_link_oe(b_link_oe), .i_link_in(b_link_in),
    .o_link_stb(b_link_stb), .o_link_we(b_link_we), .i_link_ack(b_link_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dev;
    int          delay;
    int          nack;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Device model: ack after v.delay wait cycles per beat, never on beat v.nack.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, beat, waitc;
    bit done, acked;
    logic [15:0] eo;
    logic eoe;
    chk($sformatf("v%0d_ready_idle", idx), a_req_ready, 1);
    a_req_valid = 1'b1;
    a_req_we    = v.we;
    a_req_addr  = v.addr;
    a_req_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    cyc = 1; beat = 0; waitc = 0; done = 0;
    while (!done && cyc < 100) begin
      acked = 0;
      if (a_rsp_valid) begin
        done = 1;
        chk($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
        chk($sformatf("v%0d_rsp_err", idx), a_rsp_err, v.exp_err);
        chk($sformatf("v%0d_rsp_rdata", idx), a_rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_resp_stb", idx), {a_link_stb, a_link_oe, a_link_we}, 0);
      end else begin
        if (beat < 2) begin
          eo = 16'(v.addr >> (16 * beat)); eoe = 1'b1;
        end else if (v.we) begin
          eo = 16'(v.wdata >> (16 * (beat - 2))); eoe = 1'b1;
        end else begin
          eo = 16'h0; eoe = 1'b0;
        end
        chk($sformatf("v%0d_b%0d_ctl", idx, beat),
            {a_req_ready, a_link_stb, a_link_we, a_link_oe}, {1'b0, 1'b1, v.we, eoe});
        chk($sformatf("v%0d_b%0d_out", idx, beat), a_link_out, eo);
        if (beat != v.nack && waitc == v.delay) begin
          a_link_ack = 1'b1;
          if (!v.we && beat >= 2) a_link_in = 16'(v.dev >> (16 * (beat - 2)));
          acked = 1;
        end
      end
      @(posedge clk);
      @(negedge clk);
      a_link_ack = 1'b0;
      a_link_in  = '0;
      if (acked) begin
        beat++; waitc = 0;
      end else begin
        waitc++;
      end
      cyc++;
    end
    chk($sformatf("v%0d_rsp_seen", idx), done, 1);
    chk($sformatf("v%0d_after_idle", idx),
        {a_req_ready, a_rsp_valid, a_link_stb, a_link_we}, 4'b1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp8 [10];
    exp8 = '{8'hC3, 8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

    vecs[0] = '{we:1'b1, addr:32'h0000_1234, wdata:32'hDEAD_BEEF, dev:32'h0, delay:0, nack:-1,
                exp_rdata:32'h0, exp_err:1'b0, exp_lat:5};
    vecs[1] = '{we:1'b0, addr:32'h0008_0004, wdata:32'h0, dev:32'h0BAD_CAFE, delay:3, nack:-1,
                exp_rdata:32'h0BAD_CAFE, exp_err:1'b0, exp_lat:17};
    vecs[2] = '{we:1'b0, addr:32'h0000_0010, wdata:32'h0, dev:32'h1111_2222, delay:0, nack:3,
                exp_rdata:32'h0, exp_err:1'b1, exp_lat:8};
    vecs[3] = '{we:1'b1, addr:32'h89AB_0000, wdata:32'h00FF_00FF, dev:32'h0, delay:3, nack:-1,
                exp_rdata:32'h0, exp_err:1'b0, exp_lat:17};
    vecs[4] = '{we:1'b1, addr:32'h0000_CAFE, wdata:32'h1234_5678, dev:32'h0, delay:0, nack:0,
                exp_rdata:32'h0, exp_err:1'b1, exp_lat:5};
    vecs[5] = '{we:1'b0, addr:32'hFFFF_0001, wdata:32'h0, dev:32'hA5A5_5A5A, delay:1, nack:-1,
                exp_rdata:32'hA5A5_5A5A, exp_err:1'b0, exp_lat:9};

    #3;
    chk("reset_a_ready", a_req_ready, 1);
    chk("reset_a_outs", {a_rsp_valid, a_rsp_err, a_rsp_rdata, a_link_out, a_link_oe,
                         a_link_stb, a_link_we}, 0);
    chk("reset_b_ready", b_req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Acks while idle must not start anything.
    a_link_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_ignored", {a_req_ready, a_link_stb, a_rsp_valid}, 3'b100);
    end
    a_link_ack = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset during WDATA.
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h0000_0001; a_req_wdata = 32'h0000_0002;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0; a_link_ack = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    a_link_ack = 1'b0;
    chk("rst_pre_wdata", {a_link_stb, a_link_oe, a_link_we, a_link_out}, {3'b111, 16'h0002});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {a_rsp_valid, a_rsp_err, a_rsp_rdata, a_link_out, a_link_oe,
                           a_link_stb, a_link_we}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_after_release", {a_req_ready, a_rsp_valid, a_link_stb}, 3'b100);
    end
    run_vec(0, vecs[0]);

    // 8-bit link write: two address beats then eight data beats.
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'hA5C3; b_req_wdata = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0; b_link_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b_wr_beat%0d", i), {b_link_stb, b_link_oe, b_link_we, b_link_out},
          {3'b111, exp8[i]});
      @(posedge clk);
      @(negedge clk);
    end
    b_link_ack = 1'b0;
    chk("b_wr_rsp", {b_rsp_valid, b_rsp_err, b_rsp_rdata, b_link_stb}, {2'b10, 64'h0, 1'b0});
    @(negedge clk);
    chk("b_wr_idle", b_req_ready, 1);

    // 8-bit link read: device returns 0x10..0x17 on the data beats.
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0; b_link_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b_rd_beat%0d", i), {b_link_stb, b_link_oe, b_link_we},
          (i < 2) ? 3'b110 : 3'b100);
      b_link_in = (i < 2) ? 8'h00 : 8'(8'h10 + i - 2);
      @(posedge clk);
      @(negedge clk);
    end
    b_link_ack = 1'b0; b_link_in = '0;
    chk("b_rd_rsp", {b_rsp_valid, b_rsp_err, b_rsp_rdata}, {2'b10, 64'h1716_1514_1312_1110});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
